// File: rtl/des_sbox_sequencer_if.sv
// Handshake and S-box bus bundle for des_sbox_sequencer.
// slave is the sequencer's view; master is the environment (controller, S-box stage, consumer).
interface des_sbox_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] r_in;
    logic [47:0] subkey;
    logic [2:0]  sbox_sel;
    logic [5:0]  sbox_in;
    logic        sbox_en;
    logic [3:0]  sbox_out;
    logic [31:0] f_out;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  in_valid, r_in, subkey, sbox_out, out_ready,
        output in_ready, sbox_sel, sbox_in, sbox_en, f_out, out_valid
    );

    modport master (
        output in_valid, r_in, subkey, sbox_out, out_ready,
        input  in_ready, sbox_sel, sbox_in, sbox_en, f_out, out_valid
    );
endinterface

// File: rtl/des_sbox_sequencer.sv
// Serial DES f-function: E(R)^K issued one 6-bit group per cycle to an external
// combinational S-box, nibbles collected, P applied, result held on valid/ready.
module des_sbox_sequencer (
    input  logic clk,
    input  logic rst,
    des_sbox_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Table entries are DES bit numbers (1 = MSB).
    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };
    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    function automatic logic [47:0] expand(input logic [31:0] r);
        logic [47:0] e;
        e = '0;
        for (int j = 0; j < 48; j++) e[47-j] = r[32-E_TAB[j]];
        return e;
    endfunction

    function automatic logic [31:0] permute(input logic [31:0] s);
        logic [31:0] p;
        p = '0;
        for (int j = 0; j < 32; j++) p[31-j] = s[32-P_TAB[j]];
        return p;
    endfunction

    function automatic logic [5:0] group(input logic [47:0] m, input logic [2:0] i);
        logic [47:0] t;
        t = m << (6 * i);
        return t[47:42];
    endfunction

    state_t      state;
    logic [2:0]  idx;
    logic [47:0] mix;
    logic [31:0] acc;
    logic [47:0] mix_d;
    logic [31:0] acc_next;
    logic [4:0]  nib_sh;

    always_comb begin
        // NOTE: every signal gets a value before any condition, so no latch can be inferred.
        mix_d    = expand(bus.r_in) ^ bus.subkey;
        nib_sh   = {~idx, 2'b00};
        acc_next = (acc & ~(32'hF << nib_sh)) | ({28'h0, bus.sbox_out} << nib_sh);
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            mix           <= '0;
            acc           <= '0;
            bus.f_out     <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.sbox_en   <= 1'b0;
            bus.sbox_sel  <= '0;
            bus.sbox_in   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state        <= RUN;
                        mix          <= mix_d;
                        idx          <= '0;
                        acc          <= '0;
                        bus.in_ready <= 1'b0;
                        bus.sbox_en  <= 1'b1;
                        bus.sbox_sel <= '0;
                        bus.sbox_in  <= mix_d[47:42];
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (idx == 3'd7) begin
                        state         <= DONE;
                        bus.f_out     <= permute(acc_next);
                        bus.out_valid <= 1'b1;
                        bus.sbox_en   <= 1'b0;
                        bus.sbox_sel  <= '0;
                        bus.sbox_in   <= '0;
                    end else begin
                        idx          <= idx + 3'd1;
                        bus.sbox_sel <= idx + 3'd1;
                        bus.sbox_in  <= group(mix, idx + 3'd1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    bus.sbox_en   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Scoreboard bench for des_sbox_sequencer with a DES S-box model (or constant stub) on sbox_out.
module tb_des_sbox_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    des_sbox_sequencer_if bus ();
    des_sbox_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };
    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };
    localparam int SBOX [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
    };

    logic        stub_mode = 1'b0;
    logic [3:0]  stub_val  = 4'hC;
    int          n_checks  = 0;
    int          n_fail    = 0;
    logic [31:0] exp_q [$];

    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] g);
        int ix;
        ix = int'(box) * 64 + int'({g[5], g[0]}) * 16 + int'(g[4:1]);
        return 4'(SBOX[ix]);
    endfunction

    function automatic logic [47:0] model_mix(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        e = '0;
        for (int j = 0; j < 48; j++) e[47-j] = r[32-E_TAB[j]];
        return e ^ k;
    endfunction

    function automatic logic [31:0] perm(input logic [31:0] s);
        logic [31:0] p;
        p = '0;
        for (int j = 0; j < 32; j++) p[31-j] = s[32-P_TAB[j]];
        return p;
    endfunction

    function automatic logic [5:0] grp(input logic [47:0] m, input int i);
        return m[47-6*i -: 6];
    endfunction

    function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] m;
        logic [31:0] a;
        m = model_mix(r, k);
        a = '0;
        for (int i = 0; i < 8; i++)
            a[31-4*i -: 4] = stub_mode ? stub_val : sbox_lookup(3'(i), grp(m, i));
        return perm(a);
    endfunction

    assign bus.sbox_out = stub_mode ? stub_val : sbox_lookup(bus.sbox_sel, bus.sbox_in);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push the model result at input acceptance, pop at output acceptance.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", bus.out_valid, 0);
                else                   check("scoreboard_f", bus.f_out, exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model_f(bus.r_in, bus.subkey));
        end
    end

    task automatic start_op(input logic [31:0] r, input logic [47:0] k, input bit hold);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.r_in     = r;
        bus.subkey   = k;
        tick();
        if (!hold) bus.in_valid = 1'b0;
    endtask

    // Entered in cycle 1, leaves in cycle 9.
    task automatic run_phase(input logic [47:0] mix_exp, input bit churn);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) check("mix", dut.mix, mix_exp);
            check($sformatf("sbox_en[%0d]", i), bus.sbox_en, 1);
            check($sformatf("sbox_sel[%0d]", i), bus.sbox_sel, i);
            check($sformatf("sbox_in[%0d]", i), bus.sbox_in, grp(mix_exp, i));
            check($sformatf("in_ready_run[%0d]", i), bus.in_ready, 0);
            check($sformatf("out_valid_run[%0d]", i), bus.out_valid, 0);
            if (churn) begin
                bus.r_in   = $urandom;
                bus.subkey = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            end
            tick();
        end
    endtask

    // Entered in cycle 9; out_ready is low for `stall` cycles, then high.
    task automatic done_phase(input logic [31:0] f_exp, input int stall);
        for (int s = 0; s <= stall; s++) begin
            bus.out_ready = (s == stall);
            check($sformatf("out_valid_done[%0d]", s), bus.out_valid, 1);
            check($sformatf("f_out_done[%0d]", s), bus.f_out, f_exp);
            check($sformatf("in_ready_done[%0d]", s), bus.in_ready, 0);
            check($sformatf("sbox_en_done[%0d]", s), bus.sbox_en, 0);
            tick();
        end
        check("out_valid_after", bus.out_valid, 0);
        check("in_ready_after", bus.in_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  bus.in_ready, 1);
        check({tag, "_sbox_en"},   bus.sbox_en, 0);
        check({tag, "_sbox_sel"},  bus.sbox_sel, 0);
        check({tag, "_sbox_in"},   bus.sbox_in, 0);
        check({tag, "_f_out"},     bus.f_out, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
    endtask

    localparam logic [31:0] KAT_R   = 32'hF0AA_F0AA;
    localparam logic [47:0] KAT_K   = 48'h1B02_EFFC_7072;
    localparam logic [47:0] KAT_MIX = 48'h6117_BA86_6527;
    localparam logic [31:0] KAT_F   = 32'h234A_A9BB;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [47:0] ka;
        bit          saw_valid;
        bus.in_valid  = 1'b0;
        bus.r_in      = '0;
        bus.subkey    = '0;
        bus.out_ready = 1'b1;

        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Known answer with real S-boxes.
        start_op(KAT_R, KAT_K, 0);
        run_phase(KAT_MIX, 0);
        check("kat_acc", dut.acc, 32'h5C82_B597);
        done_phase(KAT_F, 0);

        // Constant stub on sbox_out.
        stub_mode = 1'b1;
        start_op(KAT_R, KAT_K, 0);
        run_phase(KAT_MIX, 0);
        done_phase(perm(32'hCCCC_CCCC), 0);
        stub_mode = 1'b0;

        // Backpressure: out_ready low for 5 cycles.
        start_op(KAT_R, KAT_K, 0);
        run_phase(KAT_MIX, 0);
        done_phase(KAT_F, 5);

        // Busy input: in_valid held, R/K churning during RUN, second op queued.
        ra = $urandom; rb = $urandom;
        ka = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        start_op(ra, ka, 1);
        run_phase(model_mix(ra, ka), 1);
        bus.r_in   = rb;
        bus.subkey = ka;
        done_phase(model_f(ra, ka), 0);
        tick();
        bus.in_valid = 1'b0;
        run_phase(model_mix(rb, ka), 0);
        done_phase(model_f(rb, ka), 0);

        // Reset in RUN cycle 4.
        start_op(KAT_R, KAT_K, 0);
        for (int i = 0; i < 3; i++) tick();
        check("pre_abort_sel", bus.sbox_sel, 3);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            saw_valid |= bus.out_valid;
            tick();
        end
        check("abort_no_valid", saw_valid, 0);
        start_op(KAT_R, KAT_K, 0);
        run_phase(KAT_MIX, 0);
        done_phase(KAT_F, 0);

        // Zero vector.
        start_op(32'h0, 48'h0, 0);
        run_phase(48'h0, 0);
        done_phase(perm(32'hEFA7_2C4D), 0);

        // A few random operations.
        for (int n = 0; n < 3; n++) begin
            ra = $urandom;
            ka = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            start_op(ra, ka, 0);
            run_phase(model_mix(ra, ka), 0);
            done_phase(model_f(ra, ka), n);
        end

        tick();
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
